// File: rtl/fft_butterfly_arbiter_pkg.sv
// Shared constants for the FFT butterfly arbiter: default geometry and the
// operand/result slot ordering used to carry butterfly operands as arrays.
package fft_butterfly_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_Q       = 15;
  localparam int DEF_TAG_W   = 3;
  localparam int DEF_MAX_OUT = 4;

  localparam int NUM_OPS = 6;
  localparam int OP_R0   = 0;
  localparam int OP_I0   = 1;
  localparam int OP_R1   = 2;
  localparam int OP_I1   = 3;
  localparam int OP_CR   = 4;
  localparam int OP_CI   = 5;

  localparam int NUM_RES = 4;
  localparam int RS_R0   = 0;
  localparam int RS_I0   = 1;
  localparam int RS_R1   = 2;
  localparam int RS_I1   = 3;

  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fft_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or after rr_ptr,
// wrapping to the lowest set bit when nothing at or above the pointer is set.
module fft_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             hi_v;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    hi_v        = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (mask[i]) begin
        grant_valid = 1'b1;
        lo_idx      = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hi_v   = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    grant_idx = hi_v ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/fft_butterfly_arbiter.sv
// Shares one pipelined radix-2 butterfly between NUM_REQ FFT stages: one
// holding slot per stage, round-robin issue with tags, tagged result return.
module fft_butterfly_arbiter
  import fft_butterfly_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int Q       = DEF_Q,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*(Q+1)-1:0] req_real_0,
  input  logic [NUM_REQ*(Q+1)-1:0] req_imag_0,
  input  logic [NUM_REQ*(Q+1)-1:0] req_real_1,
  input  logic [NUM_REQ*(Q+1)-1:0] req_imag_1,
  input  logic [NUM_REQ*(Q+1)-1:0] req_coeff_real,
  input  logic [NUM_REQ*(Q+1)-1:0] req_coeff_imag,
  output logic [NUM_REQ-1:0]       req_pending,
  output logic                     bf_valid,
  output logic [Q:0]               bf_real_0,
  output logic [Q:0]               bf_imag_0,
  output logic [Q:0]               bf_real_1,
  output logic [Q:0]               bf_imag_1,
  output logic [Q:0]               bf_coeff_real,
  output logic [Q:0]               bf_coeff_imag,
  output logic [TAG_W-1:0]         bf_tag,
  input  logic                     bf_res_valid,
  input  logic [TAG_W-1:0]         bf_res_tag,
  input  logic [Q:0]               bf_res_real_0,
  input  logic [Q:0]               bf_res_imag_0,
  input  logic [Q:0]               bf_res_real_1,
  input  logic [Q:0]               bf_res_imag_1,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [Q:0]               rsp_real_0,
  output logic [Q:0]               rsp_imag_0,
  output logic [Q:0]               rsp_real_1,
  output logic [Q:0]               rsp_imag_1,
  output logic [NUM_REQ-1:0]       overflow_err,
  output logic                     spurious_err
);

  localparam int W     = Q + 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [TAG_W:0] TAG_LIM = (TAG_W + 1)'(NUM_REQ);

  typedef logic signed [Q:0] samp_t;

  samp_t              req_op [NUM_REQ][NUM_OPS];
  samp_t              slot_q [NUM_REQ][NUM_OPS];
  samp_t              slot_d [NUM_REQ][NUM_OPS];
  samp_t              bf_q   [NUM_OPS];
  samp_t              bf_d   [NUM_OPS];
  samp_t              rsp_q  [NUM_RES];
  samp_t              rsp_d  [NUM_RES];
  logic [NUM_REQ-1:0] full_q, full_d, ovf_q, ovf_d, rsp_valid_q, rsp_valid_d, gnt_oh;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d, bf_tag_q, bf_tag_d, grant_idx;
  logic [CNT_W-1:0]   out_q, out_d;
  logic               bf_valid_q, bf_valid_d, spur_q, spur_d;
  logic               grant_valid, issue, res_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[i][OP_R0] = req_real_0[i*W +: W];
      req_op[i][OP_I0] = req_imag_0[i*W +: W];
      req_op[i][OP_R1] = req_real_1[i*W +: W];
      req_op[i][OP_I1] = req_imag_1[i*W +: W];
      req_op[i][OP_CR] = req_coeff_real[i*W +: W];
      req_op[i][OP_CI] = req_coeff_imag[i*W +: W];
    end
  end

  fft_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_picker (
    .mask        (full_q),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // An accepted result frees a butterfly slot in the same cycle it arrives.
  assign res_ok = bf_res_valid && (out_q != '0) && ({1'b0, bf_res_tag} < TAG_LIM);
  assign issue  = grant_valid && ((out_q < CNT_W'(MAX_OUT)) || res_ok);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = issue && (grant_idx == TAG_W'(i));
    end
  end

  always_comb begin
    full_d      = full_q;
    slot_d      = slot_q;
    ovf_d       = ovf_q;
    bf_valid_d  = issue;
    bf_tag_d    = bf_tag_q;
    bf_d        = bf_q;
    rr_ptr_d    = rr_ptr_q;
    out_d       = out_q;
    rsp_valid_d = '0;
    rsp_d       = rsp_q;
    spur_d      = spur_q | (bf_res_valid & ~res_ok);
    if (issue) begin
      bf_tag_d = grant_idx;
      rr_ptr_d = TAG_W'(wrap_next(int'(grant_idx), NUM_REQ));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        bf_d      = slot_q[i];
        full_d[i] = 1'b0;
      end
      // A slot being drained this cycle may be refilled in the same cycle.
      if (req_valid[i]) begin
        if (!full_q[i] || gnt_oh[i]) begin
          full_d[i] = 1'b1;
          slot_d[i] = req_op[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
      if (res_ok && (bf_res_tag == TAG_W'(i))) rsp_valid_d[i] = 1'b1;
    end
    if (res_ok) begin
      rsp_d[RS_R0] = bf_res_real_0;
      rsp_d[RS_I0] = bf_res_imag_0;
      rsp_d[RS_R1] = bf_res_real_1;
      rsp_d[RS_I1] = bf_res_imag_1;
    end
    case ({issue, res_ok})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= '0;
      ovf_q       <= '0;
      rsp_valid_q <= '0;
      rr_ptr_q    <= '0;
      bf_tag_q    <= '0;
      out_q       <= '0;
      bf_valid_q  <= 1'b0;
      spur_q      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        for (int k = 0; k < NUM_OPS; k++) slot_q[i][k] <= '0;
      for (int k = 0; k < NUM_OPS; k++) bf_q[k] <= '0;
      for (int k = 0; k < NUM_RES; k++) rsp_q[k] <= '0;
    end else begin
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      bf_tag_q    <= bf_tag_d;
      out_q       <= out_d;
      bf_valid_q  <= bf_valid_d;
      spur_q      <= spur_d;
      slot_q      <= slot_d;
      bf_q        <= bf_d;
      rsp_q       <= rsp_d;
    end
  end

  assign req_pending   = full_q;
  assign bf_valid      = bf_valid_q;
  assign bf_tag        = bf_tag_q;
  assign bf_real_0     = bf_q[OP_R0];
  assign bf_imag_0     = bf_q[OP_I0];
  assign bf_real_1     = bf_q[OP_R1];
  assign bf_imag_1     = bf_q[OP_I1];
  assign bf_coeff_real = bf_q[OP_CR];
  assign bf_coeff_imag = bf_q[OP_CI];
  assign rsp_valid     = rsp_valid_q;
  assign rsp_real_0    = rsp_q[RS_R0];
  assign rsp_imag_0    = rsp_q[RS_I0];
  assign rsp_real_1    = rsp_q[RS_R1];
  assign rsp_imag_1    = rsp_q[RS_I1];
  assign overflow_err  = ovf_q;
  assign spurious_err  = spur_q;

endmodule

// File: tb/tb_fft_butterfly_arbiter.sv
// Bench for fft_butterfly_arbiter: directed scenarios followed by random
// traffic, all outputs checked every cycle against a transaction-level model.
module tb_fft_butterfly_arbiter;

  localparam int NR = 4;
  localparam int QQ = 15;
  localparam int TW = 3;
  localparam int MO = 4;
  localparam int W  = QQ + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_real_0 = '0, req_imag_0 = '0, req_real_1 = '0, req_imag_1 = '0;
  logic [NR*W-1:0] req_coeff_real = '0, req_coeff_imag = '0;
  logic [NR-1:0]   req_pending;
  logic            bf_valid;
  logic [QQ:0]     bf_real_0, bf_imag_0, bf_real_1, bf_imag_1, bf_coeff_real, bf_coeff_imag;
  logic [TW-1:0]   bf_tag;
  logic            bf_res_valid = 1'b0;
  logic [TW-1:0]   bf_res_tag = '0;
  logic [QQ:0]     bf_res_real_0 = '0, bf_res_imag_0 = '0, bf_res_real_1 = '0, bf_res_imag_1 = '0;
  logic [NR-1:0]   rsp_valid;
  logic [QQ:0]     rsp_real_0, rsp_imag_0, rsp_real_1, rsp_imag_1;
  logic [NR-1:0]   overflow_err;
  logic            spurious_err;

  fft_butterfly_arbiter #(.NUM_REQ(NR), .Q(QQ), .TAG_W(TW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_real_0(req_real_0), .req_imag_0(req_imag_0),
    .req_real_1(req_real_1), .req_imag_1(req_imag_1),
    .req_coeff_real(req_coeff_real), .req_coeff_imag(req_coeff_imag),
    .req_pending(req_pending), .bf_valid(bf_valid),
    .bf_real_0(bf_real_0), .bf_imag_0(bf_imag_0),
    .bf_real_1(bf_real_1), .bf_imag_1(bf_imag_1),
    .bf_coeff_real(bf_coeff_real), .bf_coeff_imag(bf_coeff_imag),
    .bf_tag(bf_tag), .bf_res_valid(bf_res_valid), .bf_res_tag(bf_res_tag),
    .bf_res_real_0(bf_res_real_0), .bf_res_imag_0(bf_res_imag_0),
    .bf_res_real_1(bf_res_real_1), .bf_res_imag_1(bf_res_imag_1),
    .rsp_valid(rsp_valid), .rsp_real_0(rsp_real_0), .rsp_imag_0(rsp_imag_0),
    .rsp_real_1(rsp_real_1), .rsp_imag_1(rsp_imag_1),
    .overflow_err(overflow_err), .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Reference model state (transaction level)
  bit          m_full [NR];
  logic [W-1:0] m_slot [NR][6];
  int          m_rr, m_out;
  logic [NR-1:0] m_ovf, m_rsp_valid;
  bit          m_spur, m_bf_valid;
  logic [TW-1:0] m_bf_tag;
  logic [W-1:0] m_bf [6];
  logic [W-1:0] m_rsp [4];
  int          issued_q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p;
    for (int i = 0; i < NR; i++) p[i] = m_full[i];
    return p;
  endfunction

  task automatic model_step();
    int g;
    bit iss, rok;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_full[i] = 0;
        for (int k = 0; k < 6; k++) m_slot[i][k] = '0;
      end
      for (int k = 0; k < 6; k++) m_bf[k] = '0;
      for (int k = 0; k < 4; k++) m_rsp[k] = '0;
      m_rr = 0; m_out = 0; m_ovf = '0; m_rsp_valid = '0;
      m_spur = 0; m_bf_valid = 0; m_bf_tag = '0;
      issued_q.delete();
      return;
    end
    rok = bf_res_valid && (m_out > 0) && (int'(bf_res_tag) < NR);
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int j = (m_rr + k) % NR;
      if (g < 0 && m_full[j]) g = j;
    end
    iss = (g >= 0) && ((m_out < MO) || rok);
    m_bf_valid = iss;
    if (iss) begin
      for (int k = 0; k < 6; k++) m_bf[k] = m_slot[g][k];
      m_bf_tag = TW'(g);
      m_rr = (g + 1) % NR;
      issued_q.push_back(g);
    end
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i]) begin
        if (!m_full[i] || (iss && g == i)) begin
          m_full[i] = 1;
          m_slot[i][0] = req_real_0[i*W +: W];
          m_slot[i][1] = req_imag_0[i*W +: W];
          m_slot[i][2] = req_real_1[i*W +: W];
          m_slot[i][3] = req_imag_1[i*W +: W];
          m_slot[i][4] = req_coeff_real[i*W +: W];
          m_slot[i][5] = req_coeff_imag[i*W +: W];
        end else m_ovf[i] = 1'b1;
      end else if (iss && g == i) m_full[i] = 0;
    end
    m_out = m_out + (iss ? 1 : 0) - (rok ? 1 : 0);
    m_rsp_valid = rok ? NR'(1 << bf_res_tag) : '0;
    if (rok) begin
      m_rsp[0] = bf_res_real_0; m_rsp[1] = bf_res_imag_0;
      m_rsp[2] = bf_res_real_1; m_rsp[3] = bf_res_imag_1;
    end
    if (bf_res_valid && !rok) m_spur = 1;
  endtask

  task automatic check_all();
    chk("bf_valid", 128'(bf_valid), 128'(m_bf_valid));
    chk("bf_tag", 128'(bf_tag), 128'(m_bf_tag));
    chk("bf_data", 128'({bf_real_0, bf_imag_0, bf_real_1, bf_imag_1, bf_coeff_real, bf_coeff_imag}),
        128'({m_bf[0], m_bf[1], m_bf[2], m_bf[3], m_bf[4], m_bf[5]}));
    chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_valid));
    chk("rsp_data", 128'({rsp_real_0, rsp_imag_0, rsp_real_1, rsp_imag_1}),
        128'({m_rsp[0], m_rsp[1], m_rsp[2], m_rsp[3]}));
    chk("req_pending", 128'(req_pending), 128'(m_pending()));
    chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
    chk("spurious_err", 128'(spurious_err), 128'(m_spur));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (bf_valid === 1'b1) pulse_cnt++;
    req_valid    = '0;
    bf_res_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] r0, input logic [W-1:0] cr);
    req_real_0[i*W +: W]     = r0;
    req_imag_0[i*W +: W]     = r0 ^ 16'h00FF;
    req_real_1[i*W +: W]     = r0 + 16'h0010;
    req_imag_1[i*W +: W]     = r0 - 16'h0020;
    req_coeff_real[i*W +: W] = cr;
    req_coeff_imag[i*W +: W] = ~cr;
  endtask

  task automatic send_res(input int tag);
    bf_res_valid  = 1'b1;
    bf_res_tag    = TW'(tag);
    bf_res_real_0 = W'($urandom);
    bf_res_imag_0 = W'($urandom);
    bf_res_real_1 = W'($urandom);
    bf_res_imag_1 = W'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic burst_all();
    for (int i = 0; i < NR; i++) set_req(i, W'(16'h0100 * (i + 1)), W'(16'h4000 + i));
    req_valid = '1;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk("reset_bf_valid", 128'(bf_valid), 128'(0));
    chk("reset_pending", 128'(req_pending), 128'(0));

    // Single request from stage 2
    set_req(2, 16'h1000, 16'h7FFF);
    req_valid = 4'b0100;
    tick();
    chk("single_pending", 128'(req_pending), 128'(4'b0100));
    chk("single_early", 128'(bf_valid), 128'(0));
    tick();
    chk("single_valid", 128'(bf_valid), 128'(1));
    chk("single_tag", 128'(bf_tag), 128'(2));
    chk("single_r0", 128'(bf_real_0), 128'(16'h1000));
    chk("single_cr", 128'(bf_coeff_real), 128'(16'h7FFF));
    send_res(2);
    tick();
    chk("single_rsp", 128'(rsp_valid), 128'(4'b0100));
    tick();
    chk("single_rsp_pulse", 128'(rsp_valid), 128'(0));

    // Fairness: two all-stage bursts from rr_ptr 0
    do_reset();
    for (int b = 0; b < 2; b++) begin
      burst_all();
      for (int k = 0; k < NR; k++) begin
        tick();
        chk("fair_tag", 128'(bf_tag), 128'(k));
      end
      for (int k = 0; k < NR; k++) begin
        send_res(k);
        tick();
      end
    end

    // Throttle at MAX_OUT
    do_reset();
    pulse_cnt = 0;
    burst_all();
    for (int k = 0; k < 4; k++) tick();
    set_req(0, 16'h0A0A, 16'h1234);
    set_req(1, 16'h0B0B, 16'h2345);
    req_valid = 4'b0011;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("throttle_cnt", 128'(pulse_cnt), 128'(4));
    chk("throttle_pending", 128'(req_pending), 128'(4'b0011));
    send_res(3);
    tick();
    chk("throttle_free_issue", 128'(bf_valid), 128'(1));
    chk("throttle_free_tag", 128'(bf_tag), 128'(0));
    tick();
    chk("throttle_hold", 128'(bf_valid), 128'(0));
    chk("throttle_cnt2", 128'(pulse_cnt), 128'(5));

    // Overflow on a full slot
    do_reset();
    burst_all();
    for (int k = 0; k < 4; k++) tick();
    set_req(1, 16'h1111, 16'h0101);
    req_valid = 4'b0010;
    tick();
    set_req(1, 16'h2222, 16'h0202);
    req_valid = 4'b0010;
    tick();
    chk("ovf_err", 128'(overflow_err), 128'(4'b0010));
    send_res(0);
    tick();
    chk("ovf_issue_tag", 128'(bf_tag), 128'(1));
    chk("ovf_first_kept", 128'(bf_real_0), 128'(16'h1111));

    // Spurious results
    do_reset();
    send_res(0);
    tick();
    chk("spur_idle_rsp", 128'(rsp_valid), 128'(0));
    chk("spur_idle_err", 128'(spurious_err), 128'(1));
    do_reset();
    set_req(3, 16'h3333, 16'h0303);
    req_valid = 4'b1000;
    tick();
    tick();
    send_res(5);
    tick();
    chk("spur_tag_rsp", 128'(rsp_valid), 128'(0));
    chk("spur_tag_err", 128'(spurious_err), 128'(1));
    send_res(3);
    tick();
    chk("spur_then_ok", 128'(rsp_valid), 128'(4'b1000));

    // Reset with three in flight and two slots full
    do_reset();
    burst_all();
    tick();
    tick();
    set_req(0, 16'h5555, 16'h0505);
    req_valid = 4'b0001;
    tick();
    chk("mid_pending", 128'(req_pending), 128'(4'b1001));
    do_reset();
    chk("mid_rst_pending", 128'(req_pending), 128'(0));
    chk("mid_rst_bf", 128'({bf_valid, bf_tag, bf_real_0, bf_coeff_imag}), 128'(0));
    for (int k = 0; k < 3; k++) begin
      send_res(k);
      tick();
      chk("mid_late_rsp", 128'(rsp_valid), 128'(0));
      chk("mid_late_spur", 128'(spurious_err), 128'(1));
    end

    // Random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid      = NR'($urandom) & NR'($urandom);
      req_real_0     = {$urandom, $urandom};
      req_imag_0     = {$urandom, $urandom};
      req_real_1     = {$urandom, $urandom};
      req_imag_1     = {$urandom, $urandom};
      req_coeff_real = {$urandom, $urandom};
      req_coeff_imag = {$urandom, $urandom};
      if (issued_q.size() > 0 && $urandom_range(0, 2) == 0) send_res(issued_q.pop_front());
      else if ($urandom_range(0, 39) == 0) send_res(NR + int'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
